// File: rtl/sema_cpu_port.sv
// sema_cpu_port: CPU-side endpoint that turns words into sema write strobes and collects peer bits into words.
module sema_cpu_port #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk_s,
  input  logic              rstn_s,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              sema_write_o_s,
  output logic              sema_data_o_s,
  input  logic              sema_is_empty_i_s,
  input  logic              sema_data_i_s,
  input  logic              sema_valid_i_s,
  output logic              sema_ready_o_s,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  typedef enum logic [1:0] {IDLE, WAIT_EMPTY, SHIFT} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] tx_sh, col, col_n;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic take, done;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = tx_valid ? WAIT_EMPTY : IDLE;
      WAIT_EMPTY: state_n = sema_is_empty_i_s ? SHIFT : WAIT_EMPTY;
      SHIFT:      state_n = (tx_cnt == LAST) ? IDLE : SHIFT;
      default:    state_n = IDLE;
    endcase
  end
  assign tx_ready       = state == IDLE;
  assign tx_busy        = state != IDLE;
  assign sema_write_o_s = state == SHIFT;
  assign sema_data_o_s  = sema_write_o_s & (MSB_FIRST ? tx_sh[DATA_W-1] : tx_sh[0]);
  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      state  <= IDLE;
      tx_sh  <= '0;
      tx_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && tx_valid) begin
        tx_sh  <= tx_data;
        tx_cnt <= '0;
      end else if (state == SHIFT) begin
        tx_sh  <= MSB_FIRST ? tx_sh << 1 : tx_sh >> 1;
        tx_cnt <= (tx_cnt == LAST) ? '0 : tx_cnt + CW'(1);
      end
    end
  end
  // only the completing bit waits for the CPU to drain rx_data
  assign sema_ready_o_s = ~(rx_valid & (rx_cnt == LAST)) | rx_ready;
  assign take  = sema_valid_i_s & sema_ready_o_s;
  assign done  = take & (rx_cnt == LAST);
  assign col_n = MSB_FIRST ? {col[DATA_W-2:0], sema_data_i_s} : {sema_data_i_s, col[DATA_W-1:1]};
  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      col      <= '0;
      rx_cnt   <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      if (take) begin
        col    <= col_n;
        rx_cnt <= done ? '0 : rx_cnt + CW'(1);
      end
      if (done) begin
        rx_data  <= col_n;
        rx_valid <= 1'b1;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
endmodule
